// File: rtl/alu16_arbiter.sv
// rtl/alu16_arbiter.sv - round-robin share of one multi-cycle alu16 between two requesters
module alu16_arbiter #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 3,
  parameter int LATENCY = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [OP_W-1:0]   r0_op,
  output logic              r0_resp_valid,
  input  logic              r0_resp_ready,
  output logic [DATA_W:0]   r0_resp_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [OP_W-1:0]   r1_op,
  output logic              r1_resp_valid,
  input  logic              r1_resp_ready,
  output logic [DATA_W:0]   r1_resp_data,
  output logic              alu_on,
  output logic [DATA_W-1:0] alu_ina,
  output logic [DATA_W-1:0] alu_inb,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W:0]   alu_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              alu_on_q;
  logic [DATA_W-1:0] ina_q;
  logic [DATA_W-1:0] inb_q;
  logic [OP_W-1:0]   op_q;
  logic              r0_resp_valid_q;
  logic              r1_resp_valid_q;
  logic [DATA_W:0]   r0_resp_data_q;
  logic [DATA_W:0]   r1_resp_data_q;
  logic              req_any;
  logic              grant_d;
  logic              resp_taken;

  // Contested cycles go to whichever requester was not served last.
  always_comb begin
    grant_d = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_d = ~last_grant_q;
    end else if (r1_valid) begin
      grant_d = 1'b1;
    end
  end

  assign req_any    = r0_valid | r1_valid;
  assign r0_ready   = (state_q == IDLE) && req_any && !grant_d;
  assign r1_ready   = (state_q == IDLE) && req_any && grant_d;
  assign resp_taken = grant_q ? r1_resp_ready : r0_resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      grant_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      alu_on_q        <= 1'b0;
      ina_q           <= '0;
      inb_q           <= '0;
      op_q            <= '0;
      r0_resp_valid_q <= 1'b0;
      r1_resp_valid_q <= 1'b0;
      r0_resp_data_q  <= '0;
      r1_resp_data_q  <= '0;
    end else begin
      alu_on_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            grant_q  <= grant_d;
            ina_q    <= grant_d ? r1_a : r0_a;
            inb_q    <= grant_d ? r1_b : r0_b;
            op_q     <= grant_d ? r1_op : r0_op;
            alu_on_q <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            if (grant_q) begin
              r1_resp_data_q  <= alu_out;
              r1_resp_valid_q <= 1'b1;
            end else begin
              r0_resp_data_q  <= alu_out;
              r0_resp_valid_q <= 1'b1;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (resp_taken) begin
            r0_resp_valid_q <= 1'b0;
            r1_resp_valid_q <= 1'b0;
            last_grant_q    <= grant_q;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_on        = alu_on_q;
  assign alu_ina       = ina_q;
  assign alu_inb       = inb_q;
  assign alu_op        = op_q;
  assign r0_resp_valid = r0_resp_valid_q;
  assign r1_resp_valid = r1_resp_valid_q;
  assign r0_resp_data  = r0_resp_data_q;
  assign r1_resp_data  = r1_resp_data_q;
  assign busy          = (state_q != IDLE);

endmodule
